pipe_out_block_arbiter: RTL and testbench

Shares one block-throttled pipe-out endpoint (16-bit, fixed block length) among N_SRC source FIFOs. It selects a source round-robin, but only when that source holds a full block payload. It then arms the endpoint's ready and sequences the block read: a header word first, then payload words pulled from the granted FIFO. It sits between the per-channel acquisition FIFOs and the host-interface pipe endpoint, running in the endpoint clock domain.

---
 rtl/pipe_out_block_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_out_block_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_block_arbiter.sv
// Round-robin arbiter sharing one block-throttled 16-bit pipe-out
// endpoint among N_SRC source FIFOs; sequences header + payload reads.
module pipe_out_block_arbiter #(
    parameter int N_SRC       = 4,
    parameter int BLOCK_WORDS = 256,
    parameter int LEVEL_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         src_enable,
    input  logic [N_SRC*LEVEL_W-1:0] src_level,
    input  logic [N_SRC*16-1:0]      src_data,
    output logic [N_SRC-1:0]         src_rd,
    output logic                     pipe_out_ready,
    input  logic                     pipe_out_blockstrobe,
    input  logic                     pipe_out_read,
    output logic [15:0]              pipe_out_data,
    output logic [3:0]               active_src,
    output logic                     busy,
    output logic                     proto_err
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [LEVEL_W-1:0] NEED = LEVEL_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        XFER
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_HEADER,
        SEL_SRC
    } sel_t;

    state_t           state, state_n;
    sel_t             sel, sel_n;
    logic [3:0]       active_n;
    logic [3:0]       rr_ptr, rr_n;
    logic [CNT_W-1:0] word_cnt, cnt_n;
    logic             ready_n;
    logic             err_n;
    logic             seq_inc;
    logic [11:0]      seq [N_SRC];

    logic [N_SRC-1:0] req;
    logic             grant_vld;
    logic [3:0]       grant_idx;
    logic [4:0]       cand;
    logic [11:0]      cur_seq;
    logic [15:0]      cur_data;

    // A source requests once it holds a full block payload
    always_comb begin
        req = '0;
        for (int i = 0; i < N_SRC; i++) begin
            req[i] = src_enable[i] &&
                     (src_level[i*LEVEL_W +: LEVEL_W] >= NEED);
        end
    end

    // First requester at or after rr_ptr, wrapping modulo N_SRC
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, rr_ptr} + 5'(k);
            if (cand >= 5'(N_SRC)) begin
                cand = cand - 5'(N_SRC);
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (!grant_vld && cand == 5'(i) && req[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = 4'(i);
                end
            end
        end
    end

    // Sequence number and read data of the granted source
    always_comb begin
        cur_seq  = '0;
        cur_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (active_src == 4'(i)) begin
                cur_seq  = seq[i];
                cur_data = src_data[i*16 +: 16];
            end
        end
    end

    // Output word chosen by the registered data select
    always_comb begin
        case (sel)
            SEL_HEADER: pipe_out_data = {active_src, cur_seq};
            SEL_SRC:    pipe_out_data = cur_data;
            default:    pipe_out_data = 16'h0000;
        endcase
    end

    // Next-state, FIFO strobes and protocol checking
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        active_n = active_src;
        rr_n     = rr_ptr;
        cnt_n    = word_cnt;
        ready_n  = pipe_out_ready;
        err_n    = proto_err;
        seq_inc  = 1'b0;
        src_rd   = '0;
        case (state)
            IDLE: begin
                if (pipe_out_read || pipe_out_blockstrobe) begin
                    err_n = 1'b1;
                end
                if (grant_vld) begin
                    active_n = grant_idx;
                    state_n  = ARMED;
                    ready_n  = 1'b1;
                    sel_n    = SEL_ZERO;
                end
            end
            ARMED: begin
                if (pipe_out_read) begin
                    err_n = 1'b1;
                end
                if (pipe_out_blockstrobe) begin
                    state_n = XFER;
                    cnt_n   = '0;
                    ready_n = 1'b0;
                end
            end
            XFER: begin
                if (pipe_out_blockstrobe) begin
                    err_n = 1'b1;
                end
                if (pipe_out_read) begin
                    if (word_cnt == '0) begin
                        sel_n = SEL_HEADER;
                        cnt_n = CNT_W'(1);
                    end else begin
                        sel_n = SEL_SRC;
                        for (int i = 0; i < N_SRC; i++) begin
                            src_rd[i] = (active_src == 4'(i));
                        end
                        if (word_cnt == LAST_WORD) begin
                            seq_inc = 1'b1;
                            state_n = IDLE;
                            if (active_src == 4'(N_SRC - 1)) begin
                                rr_n = '0;
                            end else begin
                                rr_n = active_src + 4'd1;
                            end
                        end else begin
                            cnt_n = word_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control and handshake registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sel            <= SEL_ZERO;
            active_src     <= '0;
            rr_ptr         <= '0;
            word_cnt       <= '0;
            pipe_out_ready <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            state          <= state_n;
            sel            <= sel_n;
            active_src     <= active_n;
            rr_ptr         <= rr_n;
            word_cnt       <= cnt_n;
            pipe_out_ready <= ready_n;
            proto_err      <= err_n;
        end
    end

    // Per-source block sequence counters, bumped on block completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                seq[i] <= '0;
            end
        end else if (seq_inc) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (active_src == 4'(i)) begin
                    seq[i] <= seq[i] + 12'd1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pipe_out_block_arbiter.sv
// Self-checking bench for pipe_out_block_arbiter: source FIFO models,
// transaction-level grant/seq model and a per-cycle compare process.
module tb_pipe_out_block_arbiter;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    src_enable = '0;
    logic [N*LW-1:0] src_level;
    logic [N*16-1:0] src_data;
    logic [N-1:0]    src_rd;
    logic            pipe_out_ready;
    logic            pipe_out_blockstrobe = 1'b0;
    logic            pipe_out_read = 1'b0;
    logic [15:0]     pipe_out_data;
    logic [3:0]      active_src;
    logic            busy;
    logic            proto_err;

    logic [15:0] fifo    [N][$];
    logic [15:0] model_q [N][$];
    int          cnt_push  [N] = '{default: 0};
    int          cnt_pop   [N] = '{default: 0};
    int          rd_pulses [N] = '{default: 0};
    logic [15:0] data_r    [N] = '{default: 16'h0};

    int          m_seq [N] = '{default: 0};
    int          m_rr = 0;
    logic [15:0] exp_q [$];
    logic [N-1:0] exp_rd = '0;
    logic        xfer_rd = 1'b0;
    logic        rd_d;
    logic [15:0] hdr_last;
    logic [15:0] hdr_log [8];
    int          base = 0;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [15:0] T2_HDR [8] = '{
        16'h0000, 16'h1000, 16'h2000, 16'h3000,
        16'h0001, 16'h1001, 16'h2001, 16'h3001
    };

    pipe_out_block_arbiter #(
        .N_SRC(N),
        .BLOCK_WORDS(BW),
        .LEVEL_W(LW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src_enable(src_enable),
        .src_level(src_level),
        .src_data(src_data),
        .src_rd(src_rd),
        .pipe_out_ready(pipe_out_ready),
        .pipe_out_blockstrobe(pipe_out_blockstrobe),
        .pipe_out_read(pipe_out_read),
        .pipe_out_data(pipe_out_data),
        .active_src(active_src),
        .busy(busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_src
            assign src_level[gi*LW +: LW] = LW'(cnt_push[gi] - cnt_pop[gi]);
            assign src_data[gi*16 +: 16]  = data_r[gi];
        end
    endgenerate

    // Source FIFOs: data appears the cycle after the read strobe
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (src_rd[i]) begin
                rd_pulses[i] <= rd_pulses[i] + 1;
                if (fifo[i].size() > 0) begin
                    data_r[i]  <= fifo[i].pop_front();
                    cnt_pop[i] <= cnt_pop[i] + 1;
                end
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) rd_d <= 1'b0;
        else       rd_d <= xfer_rd;
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare: read strobes every cycle, data after each read
    always @(negedge clk) begin
        if (!reset) begin
            chk("src_rd", 16'(src_rd), 16'(exp_rd));
            if (rd_d) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL data_exp: got %h expected none",
                             pipe_out_data);
                end else begin
                    chk("pipe_out_data", pipe_out_data, exp_q.pop_front());
                end
            end
        end
    end

    function automatic int predict();
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_rr + k) % N;
            if (src_enable[s] && model_q[s].size() >= BW - 1) return s;
        end
        return -1;
    endfunction

    task automatic push(input int s, input int n);
        logic [15:0] w;
        for (int k = 0; k < n; k++) begin
            w = {4'(s), 12'(base)};
            base++;
            fifo[s].push_back(w);
            model_q[s].push_back(w);
            cnt_push[s] = cnt_push[s] + 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_enable = '0;
        pipe_out_read = 1'b0;
        pipe_out_blockstrobe = 1'b0;
        xfer_rd = 1'b0;
        exp_rd = '0;
        for (int i = 0; i < N; i++) begin
            fifo[i].delete();
            model_q[i].delete();
            cnt_push[i] = cnt_pop[i];
            m_seq[i] = 0;
        end
        exp_q.delete();
        m_rr = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_block(input int n_reads, input int strobe_at,
                            input bit dis_after);
        int src;
        int c;
        int p0;
        src = predict();
        c = 0;
        while (!pipe_out_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("ready_wait", 16'(pipe_out_ready), 16'd1);
        if (!pipe_out_ready || src < 0) begin
            if (src < 0) begin
                n_vec++;
                n_err++;
                $display("FAIL grant_model: got %0d expected none", active_src);
            end
            return;
        end
        chk("grant", 16'(active_src), 16'(src));
        chk("busy_armed", 16'(busy), 16'd1);
        p0 = rd_pulses[src];
        @(posedge clk);
        #1 pipe_out_blockstrobe = 1'b1;
        @(posedge clk);
        #1 pipe_out_blockstrobe = 1'b0;
        if (dis_after) src_enable[src] = 1'b0;
        chk("ready_drop", 16'(pipe_out_ready), 16'd0);
        for (int j = 0; j < n_reads; j++) begin
            pipe_out_read = 1'b1;
            xfer_rd = 1'b1;
            pipe_out_blockstrobe = (j == strobe_at);
            exp_rd = '0;
            if (j == 0) begin
                exp_q.push_back({src[3:0], m_seq[src][11:0]});
            end else begin
                exp_rd[src] = 1'b1;
                exp_q.push_back(model_q[src].pop_front());
            end
            @(posedge clk);
            #1;
            if (j == 0) hdr_last = pipe_out_data;
        end
        pipe_out_read = 1'b0;
        pipe_out_blockstrobe = 1'b0;
        xfer_rd = 1'b0;
        exp_rd = '0;
        chk("rd_pulses", 16'(rd_pulses[src] - p0), 16'(n_reads - 1));
        if (n_reads == BW) begin
            m_seq[src] = (m_seq[src] + 1) % 4096;
            m_rr = (src + 1) % N;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_ready", 16'(pipe_out_ready), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_active", 16'(active_src), 16'd0);
        chk("rst_err", 16'(proto_err), 16'd0);
        chk("rst_data", pipe_out_data, 16'h0000);
        do_reset();

        // 1: single source, ready one cycle after level valid
        src_enable = 4'b0100;
        push(2, 7);
        @(negedge clk);
        chk("t1_ready_lat0", 16'(pipe_out_ready), 16'd0);
        @(negedge clk);
        chk("t1_ready_lat1", 16'(pipe_out_ready), 16'd1);
        chk("t1_active", 16'(active_src), 16'd2);
        do_block(BW, -1, 1'b0);
        chk("t1_header", hdr_last, 16'h2000);
        chk("t1_pulses", 16'(rd_pulses[2]), 16'd7);
        push(2, 7);
        do_block(BW, -1, 1'b0);
        chk("t1_seq_next", hdr_last, 16'h2001);

        // 2: all sources, round-robin order and ready re-arm timing
        do_reset();
        src_enable = 4'b1111;
        for (int s = 0; s < N; s++) push(s, 100);
        for (int b = 0; b < 8; b++) begin
            do_block(BW, -1, 1'b0);
            hdr_log[b] = hdr_last;
            if (b == 0) begin
                @(negedge clk);
                chk("t2_ready_gap", 16'(pipe_out_ready), 16'd0);
                chk("t2_busy_gap", 16'(busy), 16'd0);
                @(negedge clk);
                chk("t2_ready_rearm", 16'(pipe_out_ready), 16'd1);
            end
        end
        for (int b = 0; b < 8; b++) chk("t2_header", hdr_log[b], T2_HDR[b]);

        // 3: one word short is not eligible
        do_reset();
        src_enable = 4'b1010;
        push(1, 6);
        push(3, 7);
        do_block(BW, -1, 1'b0);
        chk("t3_first", hdr_last, 16'h3000);
        repeat (4) @(negedge clk);
        chk("t3_no_grant", 16'(pipe_out_ready), 16'd0);
        push(1, 1);
        do_block(BW, -1, 1'b0);
        chk("t3_second", hdr_last, 16'h1000);

        // 4: protocol violations are flagged and ignored
        do_reset();
        src_enable = 4'b0001;
        push(0, 7);
        @(negedge clk);
        chk("t4_err_clean", 16'(proto_err), 16'd0);
        do_block(BW, 3, 1'b0);
        chk("t4_err_strobe", 16'(proto_err), 16'd1);
        chk("t4_header", hdr_last, 16'h0000);
        do_reset();
        @(negedge clk);
        chk("t4_err_rst", 16'(proto_err), 16'd0);
        @(posedge clk);
        #1 pipe_out_read = 1'b1;
        @(posedge clk);
        #1 pipe_out_read = 1'b0;
        @(negedge clk);
        chk("t4_err_idle", 16'(proto_err), 16'd1);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", 16'(proto_err), 16'd1);
        chk("t4_idle_busy", 16'(busy), 16'd0);

        // 5: asynchronous reset mid-block
        do_reset();
        src_enable = 4'b0100;
        push(2, 14);
        do_block(BW, -1, 1'b0);
        do_block(3, -1, 1'b0);
        chk("t5_partial_hdr", hdr_last, 16'h2001);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_ready", 16'(pipe_out_ready), 16'd0);
        chk("t5_busy", 16'(busy), 16'd0);
        chk("t5_active", 16'(active_src), 16'd0);
        chk("t5_err", 16'(proto_err), 16'd0);
        chk("t5_data", pipe_out_data, 16'h0000);
        chk("t5_src_rd", 16'(src_rd), 16'd0);
        for (int i = 0; i < N; i++) m_seq[i] = 0;
        m_rr = 0;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_short", 16'(pipe_out_ready), 16'd0);
        push(2, 2);
        do_block(BW, -1, 1'b0);
        chk("t5_regrant_hdr", hdr_last, 16'h2000);

        // 6: disabling after blockstrobe does not abort
        do_reset();
        src_enable = 4'b0001;
        push(0, 14);
        do_block(BW, -1, 1'b1);
        chk("t6_header", hdr_last, 16'h0000);
        repeat (6) @(negedge clk);
        chk("t6_no_regrant", 16'(pipe_out_ready), 16'd0);
        chk("t6_idle", 16'(busy), 16'd0);
        src_enable = 4'b0001;
        do_block(BW, -1, 1'b0);
        chk("t6_reenable", hdr_last, 16'h0001);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
